filter: RTL and testbench

- Glitch/debounce filter for one asynchronous, slow digital input: pins, fault lines, bus strobes.
- Synchronises the input into the `clk` domain, then changes its registered output only after the synchronised input has held the same level for WIDTH consecutive clock samples.
- One instance per external input, placed between the pin (optionally inverted upstream) and the control logic.

---
 rtl/filter.sv | 74 +++++++
 tb/tb_filter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/filter.sv
// ---------------------------------------------------------------------------
// filter
//   Glitch/debounce filter for one slow asynchronous input. The raw input is
//   brought into the clk domain through a flop synchroniser. It then passes
//   through a WIDTH-deep sample history. The registered output changes only
//   once the history is uniformly high or uniformly low. Between those two
//   cases the output holds its value, which gives hysteresis.
//
// Ports
//   clk   in   system clock, all state updates on the rising edge
//   rstn  in   asynchronous active-low reset
//   i     in   raw asynchronous input, may glitch at any time
//   o     out  filtered output, driven directly by a flop
// ---------------------------------------------------------------------------
module filter #(
  parameter int unsigned WIDTH       = 8,     // 1..32
  parameter int unsigned SYNC_STAGES = 2,     // 1..4
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i,
  output logic o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]       hist_q, hist_d;
  logic                   o_q, o_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Only the branch for the configured depth is elaborated. Because of that,
  // the [N-2:0] slices are never built when N is 1.
  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      assign sync_d = i;
    end else begin : g_syncn
      assign sync_d = {sync_q[SYNC_STAGES-2:0], i};
    end

    if (WIDTH == 1) begin : g_hist1
      assign hist_d = sync_bit;
    end else begin : g_histn
      assign hist_d = {hist_q[WIDTH-2:0], sync_bit};
    end
  endgenerate

  // The output decision uses the current history, not hist_d. This costs one
  // extra edge of latency, but it keeps o a pure flop output.
  always_comb begin
    o_d = o_q;
    if (&hist_q) begin
      o_d = 1'b1;
    end else if (~|hist_q) begin
      o_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      hist_q <= {WIDTH{RESET_VALUE}};
      o_q    <= RESET_VALUE;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      o_q    <= o_d;
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_filter.sv
// ---------------------------------------------------------------------------
// tb_filter
//   Directed bench for filter. It runs two instances: the default
//   (WIDTH=8, SYNC_STAGES=2) and a minimal one (WIDTH=1, SYNC_STAGES=1).
//   Both instances share clk, rstn and i. Inputs change 1 ns after a rising
//   edge, so the next rising edge is the first to sample a new level. That
//   edge is edge k=1 in the loops below.
// ---------------------------------------------------------------------------
module tb_filter;

  logic clk = 1'b0;
  logic rstn;
  logic i;
  logic o8;
  logic o1;

  int n_checks = 0;
  int n_errors = 0;

  filter #(.WIDTH(8), .SYNC_STAGES(2), .RESET_VALUE(1'b0)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .i    (i),
    .o    (o8)
  );

  filter #(.WIDTH(1), .SYNC_STAGES(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .i    (i),
    .o    (o1)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    rstn = 1'b0;
    i    = 1'b1;

    // The output must stay low for as long as reset is held.
    repeat (5) begin
      step_edge();
      check_bit("rst_o8", o8, 1'b0);
      check_bit("rst_o1", o1, 1'b0);
    end
    i    = 1'b0;
    rstn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      step_edge();
      if (o8 || o1) seen = 1'b1;
    end
    check_bit("post_rst_low", seen, 1'b0);

    // Rising step: the wide instance follows at edge 11, the minimal one at edge 3.
    i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step_edge();
      check_bit("step_rise_o8", o8, (k >= 11));
      check_bit("step_rise_o1", o1, (k >= 3));
    end
    // Falling step: same latency in the other direction.
    i = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step_edge();
      check_bit("step_fall_o8", o8, (k < 11));
      check_bit("step_fall_o1", o1, (k < 3));
    end

    // A 7-cycle high glitch while o is low must be rejected.
    repeat (12) step_edge();
    i = 1'b1;
    repeat (7) step_edge();
    i = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      step_edge();
      if (o8) seen = 1'b1;
    end
    check_bit("glitch_hi_reject", seen, 1'b0);

    // Drive o high, then apply a 7-cycle low dip, which must be rejected.
    i = 1'b1;
    repeat (15) step_edge();
    check_bit("dip_pre_high", o8, 1'b1);
    i = 1'b0;
    repeat (7) step_edge();
    i = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      step_edge();
      if (!o8) seen = 1'b1;
    end
    check_bit("glitch_lo_reject", seen, 1'b0);

    // Minimum pulse: i is high for exactly 8 sampling edges. o8 rises at
    // edge 11 and falls at edge 19.
    i = 1'b0;
    repeat (15) step_edge();
    check_bit("minp_pre_low", o8, 1'b0);
    i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step_edge();
      if (k == 8)  i = 1'b0;
      if (k == 10) check_bit("minp_e10", o8, 1'b0);
      if (k == 11) check_bit("minp_e11", o8, 1'b1);
      if (k == 18) check_bit("minp_e18", o8, 1'b1);
      if (k == 19) check_bit("minp_e19", o8, 1'b0);
    end

    // Chatter: the input toggles every 3 clocks, so o8 must never move.
    repeat (5) step_edge();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k % 3 == 0) i = ~i;
      step_edge();
      if (o8) seen = 1'b1;
    end
    check_bit("chatter_const", seen, 1'b0);

    // Reset in the middle of a valid high run.
    i = 1'b1;
    repeat (15) step_edge();
    check_bit("mid_pre_high", o8, 1'b1);
    rstn = 1'b0;
    #1;
    check_bit("mid_async_o8", o8, 1'b0);
    check_bit("mid_async_o1", o1, 1'b0);
    repeat (3) begin
      step_edge();
      check_bit("mid_hold_o8", o8, 1'b0);
    end
    rstn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step_edge();
      check_bit("mid_rel_o8", o8, (k >= 11));
      check_bit("mid_rel_o1", o1, (k >= 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
